// File: rtl/ddr_game_if.sv
// ddr_game_if: button, lane and display signals of the DDR game controller.
// master drives the button and lane inputs; slave is the controller side.
interface ddr_game_if;
  logic [3:0]  i_btn;
  logic        i_btn_rst;
  logic [3:0]  i_lane_hit_win;
  logic [3:0]  i_lane_expire;
  logic [1:0]  o_state;
  logic [13:0] o_score;
  logic [3:0]  o_diff;
  logic [7:0]  o_combo;
  logic [2:0]  o_misses;
  logic [3:0]  o_clear_lane;
  logic        o_spawn_en;

  modport master (
    output i_btn, i_btn_rst, i_lane_hit_win, i_lane_expire,
    input  o_state, o_score, o_diff, o_combo, o_misses, o_clear_lane, o_spawn_en
  );

  modport slave (
    input  i_btn, i_btn_rst, i_lane_hit_win, i_lane_expire,
    output o_state, o_score, o_diff, o_combo, o_misses, o_clear_lane, o_spawn_en
  );
endinterface

// File: rtl/ddr_game_ctrl.sv
// ddr_game_ctrl: judges button presses against lane hit windows and owns
// score, combo, miss and difficulty for the IDLE/PLAY/GAMEOVER game flow.
// Optional macro COMBO_BONUS_EN doubles the points per hit while the combo
// (before the update) is at least 10.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for any press; counters held at 0, no spawning
// S_PLAY   | judging presses/expires, arrows may spawn
// S_OVER   | game over; score/diff/combo frozen until restart
// S_BAD    | unreachable encoding, recovers to S_IDLE
module ddr_game_ctrl #(
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned HIT_PTS    = 10,
  parameter int unsigned MAX_MISS   = 5,
  parameter int unsigned LEVEL_STEP = 100,
  parameter int unsigned MAX_DIFF   = 9
) (
  input logic       clk,
  input logic       rst,
  ddr_game_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam logic [13:0] SCORE_CAP = 14'(SCORE_MAX);
  localparam logic [7:0]  PTS_BASE  = 8'(HIT_PTS);
  localparam logic [3:0]  MISS_LIM  = 4'(MAX_MISS);
  localparam logic [15:0] STEP      = 16'(LEVEL_STEP);
  localparam logic [3:0]  DIFF_CAP  = 4'(MAX_DIFF);
`ifdef COMBO_BONUS_EN
  localparam logic [7:0]  PTS_BONUS = 8'(HIT_PTS * 2);
`endif

  state_t      state_q, state_d;
  logic [13:0] score_q, score_d;
  logic [3:0]  diff_q, diff_d;
  logic [7:0]  combo_q, combo_d;
  logic [2:0]  misses_q, misses_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  clear_q, clear_d;
  logic        spawn_q, spawn_d;
  logic [3:0]  btn_prev_q;

  logic [3:0]  press, hit, wrong, miss;
  logic [2:0]  n_hit, n_miss;
  logic [7:0]  pts;
  logic [9:0]  add;
  logic [14:0] score_sum;
  logic [13:0] score_inc;
  logic [8:0]  combo_sum;
  logic [7:0]  combo_inc;
  logic [3:0]  miss_sum;
  logic [15:0] acc_sum;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Lane judging and saturating arithmetic for one PLAY cycle.
  always_comb begin
    press  = bus.i_btn & ~btn_prev_q;
    hit    = press & bus.i_lane_hit_win;
    wrong  = press & ~bus.i_lane_hit_win;
    miss   = bus.i_lane_expire & ~hit;
    n_hit  = popcnt4(hit);
    n_miss = popcnt4(miss);
`ifdef COMBO_BONUS_EN
    pts    = (combo_q >= 8'd10) ? PTS_BONUS : PTS_BASE;
`else
    pts    = PTS_BASE;
`endif
    add       = 10'(n_hit) * 10'(pts);
    score_sum = {1'b0, score_q} + 15'(add);
    score_inc = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[13:0];
    combo_sum = {1'b0, combo_q} + 9'(n_hit);
    combo_inc = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    miss_sum  = {1'b0, misses_q} + {1'b0, n_miss};
    // Score already at the ceiling: difficulty stops being fed.
    acc_sum   = acc_q + ((score_q == SCORE_CAP) ? 16'd0 : 16'(add));
  end

  // Next-state and next-register values; restart overrides every state.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    diff_d   = diff_q;
    combo_d  = combo_q;
    misses_d = misses_q;
    acc_d    = acc_q;
    clear_d  = 4'd0;

    case (state_q)
      S_IDLE: begin
        score_d  = 14'd0;
        diff_d   = 4'd0;
        combo_d  = 8'd0;
        misses_d = 3'd0;
        acc_d    = 16'd0;
        if (|press) state_d = S_PLAY;
      end
      S_PLAY: begin
        clear_d = hit;
        score_d = score_inc;
        combo_d = ((|wrong) || (|miss)) ? 8'd0 : combo_inc;
        if (miss_sum >= MISS_LIM) begin
          misses_d = MISS_LIM[2:0];
          state_d  = S_OVER;
        end else begin
          misses_d = miss_sum[2:0];
        end
        if (acc_sum >= STEP) begin
          acc_d  = acc_sum - STEP;
          diff_d = (diff_q >= DIFF_CAP) ? DIFF_CAP : diff_q + 4'd1;
        end else begin
          acc_d  = acc_sum;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d  = S_IDLE;
        score_d  = 14'd0;
        diff_d   = 4'd0;
        combo_d  = 8'd0;
        misses_d = 3'd0;
        acc_d    = 16'd0;
      end
    endcase

    if (bus.i_btn_rst) begin
      state_d  = S_IDLE;
      score_d  = 14'd0;
      diff_d   = 4'd0;
      combo_d  = 8'd0;
      misses_d = 3'd0;
      acc_d    = 16'd0;
      clear_d  = 4'd0;
    end

    spawn_d = (state_d == S_PLAY);
  end

  // State and game registers; button history tracks in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      score_q    <= 14'd0;
      diff_q     <= 4'd0;
      combo_q    <= 8'd0;
      misses_q   <= 3'd0;
      acc_q      <= 16'd0;
      clear_q    <= 4'd0;
      spawn_q    <= 1'b0;
      btn_prev_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      diff_q     <= diff_d;
      combo_q    <= combo_d;
      misses_q   <= misses_d;
      acc_q      <= acc_d;
      clear_q    <= clear_d;
      spawn_q    <= spawn_d;
      btn_prev_q <= bus.i_btn;
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_score      = score_q;
  assign bus.o_diff       = diff_q;
  assign bus.o_combo      = combo_q;
  assign bus.o_misses     = misses_q;
  assign bus.o_clear_lane = clear_q;
  assign bus.o_spawn_en   = spawn_q;

endmodule

// File: tb/tb_ddr_game_ctrl.sv
// tb_ddr_game_ctrl: directed test of the DDR game controller.
module tb_ddr_game_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ddr_game_if bus ();

  ddr_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_btn          = 4'd0;
    bus.i_btn_rst      = 1'b0;
    bus.i_lane_hit_win = 4'd0;
    bus.i_lane_expire  = 4'd0;
  endtask

  // Press lanes in mask with their hit windows open, then release.
  task automatic hit(input logic [3:0] mask);
    bus.i_btn = mask;
    bus.i_lane_hit_win = mask;
    tick();
    bus.i_btn = 4'd0;
    bus.i_lane_hit_win = 4'd0;
    tick();
  endtask

  // Press lane 0 with no hit window: a wrong press.
  task automatic wrong_press();
    bus.i_btn = 4'b0001;
    tick();
    bus.i_btn = 4'd0;
    tick();
  endtask

  task automatic restart_and_start();
    bus.i_btn_rst = 1'b1;
    tick();
    bus.i_btn_rst = 1'b0;
    tick();
    bus.i_btn = 4'b0010;
    tick();
    bus.i_btn = 4'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_state", int'(bus.o_state), 0);
    check("rst_score", int'(bus.o_score), 0);
    check("rst_diff", int'(bus.o_diff), 0);
    check("rst_combo", int'(bus.o_combo), 0);
    check("rst_misses", int'(bus.o_misses), 0);
    check("rst_clear", int'(bus.o_clear_lane), 0);
    check("rst_spawn", int'(bus.o_spawn_en), 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_hold", int'(bus.o_state), 0);

    // Press up in IDLE: enter PLAY, press not judged.
    bus.i_btn = 4'b1000;
    tick();
    check("start_state", int'(bus.o_state), 1);
    check("start_spawn", int'(bus.o_spawn_en), 1);
    check("start_score", int'(bus.o_score), 0);
    check("start_clear", int'(bus.o_clear_lane), 0);
    bus.i_btn = 4'd0;
    tick();

    // Two simultaneous hits.
    bus.i_btn = 4'b0011;
    bus.i_lane_hit_win = 4'b0011;
    tick();
    check("dual_clear", int'(bus.o_clear_lane), 3);
    check("dual_score", int'(bus.o_score), 20);
    check("dual_combo", int'(bus.o_combo), 2);
    bus.i_btn = 4'd0;
    bus.i_lane_hit_win = 4'd0;
    tick();
    check("clear_pulse", int'(bus.o_clear_lane), 0);

    // Wrong press on lane 2.
    bus.i_btn = 4'b0100;
    tick();
    check("wrong_combo", int'(bus.o_combo), 0);
    check("wrong_score", int'(bus.o_score), 20);
    check("wrong_clear", int'(bus.o_clear_lane), 0);
    bus.i_btn = 4'd0;
    tick();

    // Lane 3 hit beats lane 3 expire.
    bus.i_btn = 4'b1000;
    bus.i_lane_hit_win = 4'b1000;
    bus.i_lane_expire = 4'b1000;
    tick();
    check("hitexp_score", int'(bus.o_score), 30);
    check("hitexp_misses", int'(bus.o_misses), 0);
    check("hitexp_clear", int'(bus.o_clear_lane), 8);
    idle_inputs();
    tick();

    // Five separate expires end the game.
    for (int i = 1; i <= 5; i++) begin
      bus.i_lane_expire = 4'b0001;
      tick();
      bus.i_lane_expire = 4'd0;
      check("miss_count", int'(bus.o_misses), i);
      check("miss_state", int'(bus.o_state), (i == 5) ? 2 : 1);
      tick();
    end
    check("over_spawn", int'(bus.o_spawn_en), 0);
    check("over_combo", int'(bus.o_combo), 0);
    bus.i_btn = 4'b0001;
    bus.i_lane_hit_win = 4'b0001;
    tick();
    check("over_score", int'(bus.o_score), 30);
    check("over_clear", int'(bus.o_clear_lane), 0);
    check("over_state", int'(bus.o_state), 2);
    idle_inputs();
    tick();
    bus.i_btn_rst = 1'b1;
    tick();
    bus.i_btn_rst = 1'b0;
    check("restart_state", int'(bus.o_state), 0);
    check("restart_score", int'(bus.o_score), 0);
    check("restart_misses", int'(bus.o_misses), 0);
    check("restart_combo", int'(bus.o_combo), 0);
    check("restart_spawn", int'(bus.o_spawn_en), 0);
    tick();

    // Ten single hits reach score 100 and difficulty 1; the 11th shows bonus.
    bus.i_btn = 4'b0001;
    tick();
    bus.i_btn = 4'd0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      hit(4'b0001);
      if (i == 9) check("diff_before", int'(bus.o_diff), 0);
    end
    check("ten_score", int'(bus.o_score), 100);
    check("ten_diff", int'(bus.o_diff), 1);
    check("ten_combo", int'(bus.o_combo), 10);
    hit(4'b0001);
`ifdef COMBO_BONUS_EN
    check("eleventh_score", int'(bus.o_score), 120);
`else
    check("eleventh_score", int'(bus.o_score), 110);
`endif

    // Four-lane hits of 40 points; a wrong press every two hits keeps the
    // combo below 10 so the points per hit stay 10 in both builds.
    restart_and_start();
    for (int k = 1; k <= 251; k++) begin
      hit(4'b1111);
      if (k == 10) begin
        check("run_score_400", int'(bus.o_score), 400);
        check("run_diff_4", int'(bus.o_diff), 4);
      end
      if (k == 22) check("run_diff_8", int'(bus.o_diff), 8);
      if (k == 23) begin
        check("run_score_920", int'(bus.o_score), 920);
        check("run_diff_9", int'(bus.o_diff), 9);
      end
      if (k == 249) check("run_score_9960", int'(bus.o_score), 9960);
      if (k == 250) check("run_score_sat", int'(bus.o_score), 9999);
      if (k % 2 == 0) wrong_press();
    end
    check("run_score_hold", int'(bus.o_score), 9999);
    check("run_diff_hold", int'(bus.o_diff), 9);
    check("run_state", int'(bus.o_state), 1);
    check("run_misses", int'(bus.o_misses), 0);

    // Asynchronous reset mid-PLAY.
    restart_and_start();
    for (int i = 0; i < 5; i++) hit(4'b0100);
    check("pre_rst_score", int'(bus.o_score), 50);
    #2;
    rst = 1'b1;
    #1;
    check("async_score", int'(bus.o_score), 0);
    check("async_state", int'(bus.o_state), 0);
    check("async_spawn", int'(bus.o_spawn_en), 0);
    check("async_combo", int'(bus.o_combo), 0);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_state", int'(bus.o_state), 0);
    check("post_rst_spawn", int'(bus.o_spawn_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
